// File: rtl/brightness_envelope_ctrl_if.sv
// Trigger bus from the audio side into the envelope controller.
// Events are single-cycle and are never back-pressured.
interface brightness_envelope_ctrl_if;
  logic       trig_dry_valid;
  logic [7:0] trig_dry_level;
  logic       trig_delay_valid;
  logic [7:0] trig_delay_level;
  logic [2:0] delay_src_in;

  modport master (
    output trig_dry_valid,
    output trig_dry_level,
    output trig_delay_valid,
    output trig_delay_level,
    output delay_src_in
  );

  modport slave (
    input trig_dry_valid,
    input trig_dry_level,
    input trig_delay_valid,
    input trig_delay_level,
    input delay_src_in
  );
endinterface

// File: rtl/brightness_envelope_ctrl.sv
// Per-frame attack/decay brightness envelope for the dry and delay channels.
// Triggers are merged at any time and applied only at the start of vblank.
module brightness_envelope_ctrl #(
  parameter int ACTIVE_H    = 1280,
  parameter int ACTIVE_V    = 720,
  parameter int ATTACK_STEP = 64,
  parameter int DECAY_STEP  = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [10:0]                       h_count_in,
  input  logic [9:0]                        v_count_in,
  brightness_envelope_ctrl_if.slave         trig,
  output logic [7:0]                        brightness_from_dry,
  output logic [7:0]                        brightness_from_delay,
  output logic [2:0]                        delay_src,
  output logic                              frame_tick
);

  localparam int NUM_CH = 2;
  localparam logic [2:0] SRC_OFF = 3'b111;

  typedef enum logic [1:0] {IDLE, ATTACK, DECAY} env_st_t;

  logic       b;
  logic       vld    [NUM_CH];
  logic [7:0] lvl    [NUM_CH];
  logic       kill   [NUM_CH];
  logic       drop   [NUM_CH];
  logic [7:0] bright [NUM_CH];

  // A zero-width active region would never produce a first column.
  assign b = (h_count_in == '0) && (v_count_in == 10'(ACTIVE_V)) && (ACTIVE_H > 0);

  assign vld[0]  = trig.trig_dry_valid;
  assign lvl[0]  = trig.trig_dry_level;
  assign vld[1]  = trig.trig_delay_valid;
  assign lvl[1]  = trig.trig_delay_level;
  assign kill[0] = 1'b0;
  assign drop[0] = 1'b0;
  assign kill[1] = (delay_src == SRC_OFF) || (trig.delay_src_in == SRC_OFF);
  assign drop[1] = (delay_src == SRC_OFF);

  assign brightness_from_dry   = bright[0];
  assign brightness_from_delay = bright[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_tick <= 1'b0;
      delay_src  <= '0;
    end else begin
      frame_tick <= b;
      if (b) delay_src <= trig.delay_src_in;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    env_st_t    st, st_nx;
    logic [7:0] tgt, tgt_nx, bright_nx, pend_lvl, eff;
    logic [8:0] up, dn;

    always_comb begin
      st_nx     = st;
      bright_nx = bright[c];
      tgt_nx    = tgt;
      eff       = (vld[c] && (lvl[c] > pend_lvl)) ? lvl[c] : pend_lvl;
      up        = {1'b0, bright[c]} + 9'(ATTACK_STEP);
      dn        = {1'b0, bright[c]} - 9'(DECAY_STEP);
      if (kill[c]) begin
        st_nx     = IDLE;
        bright_nx = '0;
        tgt_nx    = '0;
      end else if (eff != '0) begin
        // A weaker hit during an envelope only retargets; brightness never dips.
        tgt_nx = eff;
        if (bright[c] < eff) begin
          st_nx     = ATTACK;
          bright_nx = (up >= {1'b0, eff}) ? eff : up[7:0];
        end else begin
          st_nx = DECAY;
        end
      end else begin
        case (st)
          ATTACK: begin
            if (up >= {1'b0, tgt}) begin
              bright_nx = tgt;
              st_nx     = DECAY;
            end else begin
              bright_nx = up[7:0];
            end
          end
          DECAY: begin
            if (dn[8] || (dn == '0)) begin
              bright_nx = '0;
              st_nx     = IDLE;
            end else begin
              bright_nx = dn[7:0];
            end
          end
          default: bright_nx = '0;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        st        <= IDLE;
        bright[c] <= '0;
        tgt       <= '0;
        pend_lvl  <= '0;
      end else if (b) begin
        st        <= st_nx;
        bright[c] <= bright_nx;
        tgt       <= tgt_nx;
        pend_lvl  <= '0;
      end else if (vld[c] && !drop[c] && (lvl[c] > pend_lvl)) begin
        pend_lvl <= lvl[c];
      end
    end
  end

endmodule

// File: tb/tb_brightness_envelope_ctrl.sv
// Directed bench for brightness_envelope_ctrl; drives h/v counts directly so a
// frame is a few cycles, with hand-computed envelope sequences.
module tb_brightness_envelope_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] h;
  logic [9:0]  v;
  logic [7:0]  dry, dly;
  logic [2:0]  dsrc;
  logic        tick;
  int          n_run = 0;
  int          n_fail = 0;

  brightness_envelope_ctrl_if bus ();

  brightness_envelope_ctrl dut (
    .clk                   (clk),
    .rst                   (rst),
    .h_count_in            (h),
    .v_count_in            (v),
    .trig                  (bus.slave),
    .brightness_from_dry   (dry),
    .brightness_from_delay (dly),
    .delay_src             (dsrc),
    .frame_tick            (tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, return 1 time unit after the posedge.
  task automatic cyc(input int hh, input int vv, input int dv, input int dl,
                     input int yv, input int yl);
    @(negedge clk);
    h = 11'(hh);
    v = 10'(vv);
    bus.trig_dry_valid   = (dv != 0);
    bus.trig_dry_level   = 8'(dl);
    bus.trig_delay_valid = (yv != 0);
    bus.trig_delay_level = 8'(yl);
    @(posedge clk);
    #1;
  endtask

  // Mid-frame cycle with optional triggers, an idle cycle, then the boundary.
  task automatic frame(input int dv, input int dl, input int yv, input int yl);
    cyc(7, 100, dv, dl, yv, yl);
    cyc(9, 100, 0, 0, 0, 0);
    check("tick_low_mid", {31'b0, tick}, 0);
    cyc(0, 720, 0, 0, 0, 0);
    check("tick_at_b", {31'b0, tick}, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    h = 11'd7;
    v = 10'd100;
    bus.trig_dry_valid   = 1'b0;
    bus.trig_dry_level   = '0;
    bus.trig_delay_valid = 1'b0;
    bus.trig_delay_level = '0;
    bus.delay_src_in     = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_dry",  {24'b0, dry}, 0);
    check("rst_dly",  {24'b0, dly}, 0);
    check("rst_src",  {29'b0, dsrc}, 0);
    check("rst_tick", {31'b0, tick}, 0);

    // 1: idle frames, tick only at exactly (0,720)
    for (int f = 0; f < 3; f++) begin
      frame(0, 0, 0, 0);
      check("t1_dry", {24'b0, dry}, 0);
      check("t1_dly", {24'b0, dly}, 0);
    end
    cyc(0, 719, 0, 0, 0, 0);
    check("t1_tick_v719", {31'b0, tick}, 0);
    cyc(5, 720, 0, 0, 0, 0);
    check("t1_tick_h5", {31'b0, tick}, 0);

    // 2: dry 200, held until boundary, attack then 50 decay frames to IDLE
    cyc(7, 100, 1, 200, 0, 0);
    cyc(9, 100, 0, 0, 0, 0);
    check("t2_hold", {24'b0, dry}, 0);
    cyc(0, 720, 0, 0, 0, 0);
    check("t2_a1", {24'b0, dry}, 64);
    cyc(1, 720, 0, 0, 0, 0);
    check("t2_tick_drop", {31'b0, tick}, 0);
    check("t2_hold_after_b", {24'b0, dry}, 64);
    frame(0, 0, 0, 0); check("t2_a2", {24'b0, dry}, 128);
    frame(0, 0, 0, 0); check("t2_a3", {24'b0, dry}, 192);
    frame(0, 0, 0, 0); check("t2_a4", {24'b0, dry}, 200);
    for (int k = 1; k <= 50; k++) begin
      frame(0, 0, 0, 0);
      check("t2_decay", {24'b0, dry}, 32'(200 - 4 * k));
    end
    frame(0, 0, 0, 0); check("t2_idle", {24'b0, dry}, 0);

    // 3: two hits in one frame, the larger wins
    do_reset();
    cyc(7, 100, 1, 100, 0, 0);
    cyc(8, 100, 1, 180, 0, 0);
    cyc(0, 720, 0, 0, 0, 0);
    check("t3_a1", {24'b0, dry}, 64);
    frame(0, 0, 0, 0); check("t3_a2", {24'b0, dry}, 128);
    frame(0, 0, 0, 0); check("t3_a3", {24'b0, dry}, 180);
    frame(0, 0, 0, 0); check("t3_d1", {24'b0, dry}, 176);

    // 4: weaker hit during decay does not dip; reset discards a pending hit
    do_reset();
    frame(1, 150, 0, 0); check("t4_a1", {24'b0, dry}, 64);
    frame(0, 0, 0, 0);   check("t4_a2", {24'b0, dry}, 128);
    frame(0, 0, 0, 0);   check("t4_a3", {24'b0, dry}, 150);
    frame(1, 90, 0, 0);  check("t4_nodip", {24'b0, dry}, 150);
    frame(0, 0, 0, 0);   check("t4_d1", {24'b0, dry}, 146);
    frame(0, 0, 0, 0);   check("t4_d2", {24'b0, dry}, 142);
    cyc(7, 100, 1, 99, 1, 99);
    do_reset();
    check("t4_rst_mid", {24'b0, dry}, 0);
    frame(0, 0, 0, 0);
    check("t4_pend_lost_dry", {24'b0, dry}, 0);
    check("t4_pend_lost_dly", {24'b0, dly}, 0);

    // 5: trigger on the boundary cycle itself
    do_reset();
    cyc(0, 720, 1, 40, 0, 0);
    check("t5_coinc", {24'b0, dry}, 40);
    check("t5_tick", {31'b0, tick}, 1);
    frame(0, 0, 0, 0); check("t5_hold", {24'b0, dry}, 40);
    frame(0, 0, 0, 0); check("t5_d1", {24'b0, dry}, 36);
    do_reset();
    cyc(7, 100, 1, 60, 0, 0);
    cyc(0, 720, 1, 20, 0, 0);
    check("t5_merge_max", {24'b0, dry}, 60);

    // saturation at 255 and decay floor at 0 from a non-multiple of the step
    do_reset();
    frame(1, 255, 0, 0); check("sat_a1", {24'b0, dry}, 64);
    frame(0, 0, 0, 0);   check("sat_a2", {24'b0, dry}, 128);
    frame(0, 0, 0, 0);   check("sat_a3", {24'b0, dry}, 192);
    frame(0, 0, 0, 0);   check("sat_a4", {24'b0, dry}, 255);
    for (int k = 1; k <= 64; k++) begin
      frame(0, 0, 0, 0);
      check("sat_decay", {24'b0, dry}, (255 - 4 * k > 0) ? 32'(255 - 4 * k) : 32'd0);
    end

    // 6: delay disable via source 3'b111
    do_reset();
    bus.delay_src_in = 3'd2;
    frame(1, 200, 1, 120);
    check("t6_dly_a1", {24'b0, dly}, 64);
    check("t6_src2", {29'b0, dsrc}, 2);
    frame(0, 0, 0, 0);
    check("t6_dly_a2", {24'b0, dly}, 120);
    check("t6_dry_a2", {24'b0, dry}, 128);
    bus.delay_src_in = 3'b111;
    cyc(7, 100, 0, 0, 0, 0);
    check("t6_src_hold", {29'b0, dsrc}, 2);
    cyc(0, 720, 0, 0, 0, 0);
    check("t6_dly_off", {24'b0, dly}, 0);
    check("t6_src7", {29'b0, dsrc}, 7);
    check("t6_dry_a3", {24'b0, dry}, 192);
    bus.delay_src_in = 3'd3;
    frame(0, 0, 1, 255);
    check("t6_dly_forced", {24'b0, dly}, 0);
    check("t6_src3", {29'b0, dsrc}, 3);
    check("t6_dry_a4", {24'b0, dry}, 200);
    frame(0, 0, 0, 0);
    check("t6_dly_dropped", {24'b0, dly}, 0);
    check("t6_dry_d1", {24'b0, dry}, 196);
    frame(0, 0, 1, 50);
    check("t6_dly_reenabled", {24'b0, dly}, 50);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
